// File: rtl/run_ctrl_pkg.sv
// Shared types for the commit run controller: run state and end-of-run cause encodings.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    ERROR   = 3'd1,
    TARGET  = 3'd2,
    HALT    = 3'd3,
    TIMEOUT = 3'd4
  } run_cause_t;

endpackage

// File: rtl/commit_popcount.sv
// Combinational count of retiring lanes in one cycle.
module commit_popcount #(
  parameter int NUM_LANES = 2,
  parameter int PC_W      = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0] commit_valid,
  output logic [PC_W-1:0]      count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      count = count + PC_W'(commit_valid[i]);
    end
  end

endmodule

// File: rtl/commit_run_controller.sv
// Run controller: counts retired instructions, emits progress pulses and ends the run
// on error, instruction target, halt or timeout (in that priority), then drains.
module commit_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_LANES         = 2,
  parameter int CNT_WIDTH         = 64,
  parameter int TMO_WIDTH         = 32,
  parameter int PROGRESS_INTERVAL = 10000,
  parameter int DRAIN_CYCLES      = 5,
  parameter int NUM_ERR           = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_target,
  input  logic [TMO_WIDTH-1:0] cfg_timeout,
  input  logic                 cfg_tmo_mode,
  input  logic [NUM_LANES-1:0] commit_valid,
  input  logic                 halt,
  input  logic [NUM_ERR-1:0]   err,
  output logic [CNT_WIDTH-1:0] inst_count,
  output logic                 progress_pulse,
  output logic [1:0]           state,
  output logic [2:0]           cause,
  output logic [NUM_ERR-1:0]   err_src,
  output logic                 finish
);

  localparam int PC_W  = $clog2(NUM_LANES + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] INTERVAL   = CNT_WIDTH'(PROGRESS_INTERVAL);
  localparam logic [DRN_W-1:0]     DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  if (PROGRESS_INTERVAL < NUM_LANES) begin : g_bad_interval
    $error("PROGRESS_INTERVAL must be >= NUM_LANES");
  end
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("DRAIN_CYCLES must be >= 1");
  end

  function automatic logic [CNT_WIDTH-1:0] sat_add_cnt(input logic [CNT_WIDTH-1:0] a,
                                                       input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [TMO_WIDTH-1:0] sat_inc_tmo(input logic [TMO_WIDTH-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  run_state_t           st_q;
  run_cause_t           cause_q;
  run_cause_t           cause_now;
  logic [CNT_WIDTH-1:0] target_q;
  logic [TMO_WIDTH-1:0] tmo_q;
  logic                 tmo_mode_q;
  logic [CNT_WIDTH-1:0] milestone_q;
  logic [TMO_WIDTH-1:0] elapsed_q;
  logic [DRN_W-1:0]     drain_cnt_q;
  logic [PC_W-1:0]      lane_cnt;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 active;
  logic                 any_commit;

  commit_popcount #(
    .NUM_LANES (NUM_LANES),
    .PC_W      (PC_W)
  ) u_popcount (
    .commit_valid (commit_valid),
    .count        (lane_cnt)
  );

  assign active     = (st_q == RUN) || (st_q == DRAIN);
  assign any_commit = |commit_valid;
  assign count_next = sat_add_cnt(inst_count, CNT_WIDTH'(lane_cnt));

  always_comb begin
    cause_now = NONE;
    if (err != '0) begin
      cause_now = ERROR;
    end else if ((target_q != '0) && (count_next >= target_q)) begin
      cause_now = TARGET;
    end else if (halt) begin
      cause_now = HALT;
    end else if ((tmo_q != '0) && (elapsed_q == tmo_q)) begin
      cause_now = TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q           <= IDLE;
      cause_q        <= NONE;
      inst_count     <= '0;
      err_src        <= '0;
      progress_pulse <= 1'b0;
      finish         <= 1'b0;
      target_q       <= '0;
      tmo_q          <= '0;
      tmo_mode_q     <= 1'b0;
      milestone_q    <= INTERVAL;
      elapsed_q      <= '0;
      drain_cnt_q    <= '0;
    end else begin
      progress_pulse <= 1'b0;

      if (active) begin
        inst_count <= count_next;
        err_src    <= err_src | err;
        // One milestone per cycle suffices since a cycle adds at most NUM_LANES <= interval.
        if (count_next >= milestone_q) begin
          progress_pulse <= 1'b1;
          milestone_q    <= sat_add_cnt(milestone_q, INTERVAL);
        end
      end

      unique case (st_q)
        IDLE, DONE: begin
          if (start) begin
            st_q        <= RUN;
            cause_q     <= NONE;
            finish      <= 1'b0;
            target_q    <= cfg_target;
            tmo_q       <= cfg_timeout;
            tmo_mode_q  <= cfg_tmo_mode;
            inst_count  <= '0;
            err_src     <= '0;
            milestone_q <= INTERVAL;
            elapsed_q   <= '0;
            drain_cnt_q <= '0;
          end
        end
        RUN: begin
          elapsed_q <= (tmo_mode_q && any_commit) ? '0 : sat_inc_tmo(elapsed_q);
          if (cause_now != NONE) begin
            cause_q     <= cause_now;
            st_q        <= DRAIN;
            drain_cnt_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            st_q   <= DONE;
            finish <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign state = st_q;
  assign cause = cause_q;

endmodule

// File: tb/tb_commit_run_controller.sv
// Directed bench for commit_run_controller with hand-computed expectations.
module tb_commit_run_controller;

  localparam int NL  = 2;
  localparam int CW  = 16;
  localparam int TW  = 8;
  localparam int NE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_target;
  logic [TW-1:0] cfg_timeout;
  logic          cfg_tmo_mode;
  logic [NL-1:0] commit_valid;
  logic          halt;
  logic [NE-1:0] err;
  logic [CW-1:0] inst_count;
  logic          progress_pulse;
  logic [1:0]    state;
  logic [2:0]    cause;
  logic [NE-1:0] err_src;
  logic          finish;

  int vectors = 0;
  int miscompares = 0;
  int pulses;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam logic [2:0] C_NONE = 3'd0, C_ERROR = 3'd1, C_TARGET = 3'd2, C_HALT = 3'd3,
                         C_TIMEOUT = 3'd4;

  commit_run_controller #(
    .NUM_LANES         (NL),
    .CNT_WIDTH         (CW),
    .TMO_WIDTH         (TW),
    .PROGRESS_INTERVAL (10),
    .DRAIN_CYCLES      (5),
    .NUM_ERR           (NE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_target     (cfg_target),
    .cfg_timeout    (cfg_timeout),
    .cfg_tmo_mode   (cfg_tmo_mode),
    .commit_valid   (commit_valid),
    .halt           (halt),
    .err            (err),
    .inst_count     (inst_count),
    .progress_pulse (progress_pulse),
    .state          (state),
    .cause          (cause),
    .err_src        (err_src),
    .finish         (finish)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_drain(input logic [CW-1:0] exp_count);
    for (int i = 0; i < 4; i++) tick();
    chk("drain_not_done", {63'd0, finish}, 64'd0);
    tick();
    chk("done_state", 64'(state), 64'(S_DONE));
    chk("done_finish", {63'd0, finish}, 64'd1);
    chk("done_count", 64'(inst_count), 64'(exp_count));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_target = '0; cfg_timeout = '0; cfg_tmo_mode = 1'b0;
    commit_valid = '0; halt = 1'b0; err = '0;
    tick(); tick();
    chk("rst_state", 64'(state), 64'(S_IDLE));
    chk("rst_cause", 64'(cause), 64'(C_NONE));
    chk("rst_count", 64'(inst_count), 64'd0);
    chk("rst_errsrc", 64'(err_src), 64'd0);
    chk("rst_pulse", {63'd0, progress_pulse}, 64'd0);
    chk("rst_finish", {63'd0, finish}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_no_count", 64'(state), 64'(S_IDLE));

    // Target 20, two lanes every cycle
    cfg_target = 16'd20; start = 1'b1;
    tick();
    chk("t1_run", 64'(state), 64'(S_RUN));
    start = 1'b0; commit_valid = 2'b11; pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t1_count", 64'(inst_count), 64'(2 * (k + 1)));
      chk("t1_pulse", {63'd0, progress_pulse}, {63'd0, (k == 4) || (k == 9)});
      if (progress_pulse) pulses++;
    end
    chk("t1_state", 64'(state), 64'(S_DRAIN));
    chk("t1_cause", 64'(cause), 64'(C_TARGET));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (progress_pulse) pulses++;
    end
    chk("t1_drain_finish", {63'd0, finish}, 64'd0);
    tick();
    if (progress_pulse) pulses++;
    chk("t1_done", 64'(state), 64'(S_DONE));
    chk("t1_finish", {63'd0, finish}, 64'd1);
    chk("t1_count30", 64'(inst_count), 64'd30);
    chk("t1_pulses", 64'(pulses), 64'd3);
    tick();
    chk("t1_done_hold", 64'(inst_count), 64'd30);

    // Start in DONE with concurrent halt/err: start wins; then single-lane progress
    cfg_target = '0; start = 1'b1; halt = 1'b1; err = 3'b001; commit_valid = 2'b01;
    tick();
    chk("t2_run", 64'(state), 64'(S_RUN));
    chk("t2_cause", 64'(cause), 64'(C_NONE));
    chk("t2_errsrc", 64'(err_src), 64'd0);
    chk("t2_count0", 64'(inst_count), 64'd0);
    chk("t2_finish", {63'd0, finish}, 64'd0);
    start = 1'b0; halt = 1'b0; err = '0; pulses = 0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      chk("t2_pulse", {63'd0, progress_pulse}, {63'd0, (k % 10) == 0});
      if (progress_pulse) pulses++;
    end
    chk("t2_pulses", 64'(pulses), 64'd3);
    chk("t2_count", 64'(inst_count), 64'd35);
    chk("t2_still_run", 64'(state), 64'(S_RUN));
    halt = 1'b1;
    tick();
    halt = 1'b0; commit_valid = '0;
    chk("t2_halt", 64'(cause), 64'(C_HALT));
    chk("t2_halt_cnt", 64'(inst_count), 64'd36);
    run_drain(16'd36);

    // Error, target and halt in the same cycle
    cfg_target = 16'd2; start = 1'b1;
    tick();
    start = 1'b0; commit_valid = 2'b11; err = 3'b010; halt = 1'b1;
    tick();
    chk("t3_state", 64'(state), 64'(S_DRAIN));
    chk("t3_cause", 64'(cause), 64'(C_ERROR));
    chk("t3_errsrc", 64'(err_src), 64'b010);
    commit_valid = '0; halt = 1'b0; err = 3'b100; start = 1'b1;
    tick();
    chk("t3_start_ignored", 64'(state), 64'(S_DRAIN));
    chk("t3_errsrc_drain", 64'(err_src), 64'b110);
    chk("t3_cause_kept", 64'(cause), 64'(C_ERROR));
    err = '0; start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t3_drain_len", 64'(state), 64'(S_DRAIN));
    tick();
    chk("t3_done", 64'(state), 64'(S_DONE));
    chk("t3_finish", {63'd0, finish}, 64'd1);

    // Mode 1 watchdog: commits in RUN cycles 0..4, elapsed hits 8 in cycle 13
    cfg_target = '0; cfg_timeout = 8'd8; cfg_tmo_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      commit_valid = (c < 5) ? 2'b01 : 2'b00;
      tick();
    end
    chk("t4_m1_not_yet", 64'(state), 64'(S_RUN));
    tick();
    chk("t4_m1_state", 64'(state), 64'(S_DRAIN));
    chk("t4_m1_cause", 64'(cause), 64'(C_TIMEOUT));
    chk("t4_m1_count", 64'(inst_count), 64'd5);
    run_drain(16'd5);

    // Mode 0, same stimulus: timeout in RUN cycle 8
    cfg_tmo_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      commit_valid = (c < 5) ? 2'b01 : 2'b00;
      tick();
    end
    chk("t4_m0_not_yet", 64'(state), 64'(S_RUN));
    tick();
    chk("t4_m0_state", 64'(state), 64'(S_DRAIN));
    chk("t4_m0_cause", 64'(cause), 64'(C_TIMEOUT));
    run_drain(16'd5);

    // Halt at count 100 with a far target
    cfg_target = 16'd60000; cfg_timeout = '0; start = 1'b1;
    tick();
    start = 1'b0; commit_valid = 2'b11;
    for (int c = 0; c < 50; c++) tick();
    chk("t5_count100", 64'(inst_count), 64'd100);
    commit_valid = '0; halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t5_cause", 64'(cause), 64'(C_HALT));
    chk("t5_count", 64'(inst_count), 64'd100);
    commit_valid = 2'b11;
    tick();
    commit_valid = '0;
    for (int i = 0; i < 3; i++) tick();
    tick();
    chk("t5_done", 64'(state), 64'(S_DONE));
    chk("t5_final_count", 64'(inst_count), 64'd102);
    commit_valid = 2'b11;
    tick();
    chk("t5_no_count_done", 64'(inst_count), 64'd102);
    commit_valid = '0;

    // Async reset during DRAIN, then a clean run
    cfg_target = '0; start = 1'b1;
    tick();
    start = 1'b0; commit_valid = 2'b11; err = 3'b001;
    tick();
    err = '0;
    tick();
    chk("t6_in_drain", 64'(state), 64'(S_DRAIN));
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_state", 64'(state), 64'(S_IDLE));
    chk("t6_rst_cause", 64'(cause), 64'(C_NONE));
    chk("t6_rst_count", 64'(inst_count), 64'd0);
    chk("t6_rst_errsrc", 64'(err_src), 64'd0);
    chk("t6_rst_finish", {63'd0, finish}, 64'd0);
    chk("t6_rst_pulse", {63'd0, progress_pulse}, 64'd0);
    rst = 1'b0; commit_valid = '0;
    tick();
    chk("t6_idle", 64'(state), 64'(S_IDLE));
    cfg_target = 16'd4; start = 1'b1;
    tick();
    start = 1'b0; commit_valid = 2'b11;
    tick();
    chk("t6_run_cnt", 64'(inst_count), 64'd2);
    tick();
    chk("t6_cause", 64'(cause), 64'(C_TARGET));
    chk("t6_count", 64'(inst_count), 64'd4);
    chk("t6_errsrc", 64'(err_src), 64'd0);
    commit_valid = '0;
    run_drain(16'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
